// File: rtl/alu_operand_stage_pkg.sv
// Shared datapath width and ALU operand-select encodings for the operand stage.
// Constants only; no logic.
package alu_operand_stage_pkg;

  localparam int REG_LEN = 32;

  localparam logic [1:0] ALU1_RS1    = 2'd0;
  localparam logic [1:0] ALU1_PC     = 2'd1;
  localparam logic [1:0] ALU1_ZERO   = 2'd2;

  localparam logic [1:0] ALU2_RS2    = 2'd0;
  localparam logic [1:0] ALU2_IMM    = 2'd1;
  localparam logic [1:0] ALU2_CONST4 = 2'd2;

  localparam logic [1:0] SEL_ZERO    = 2'd3;

endpackage

// File: rtl/alu_operand_stage_fwd_unit.sv
// Bypass mux for one source register: EX result, then MEM result, then register file.
// Purely combinational, no backpressure; x0 is never bypassed.
module fwd_unit #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] rs_addr,
  input  logic [WIDTH-1:0] rs_d,
  input  logic             ex_rd_we,
  input  logic [RADDR-1:0] ex_rd_addr,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             ex_is_load,
  input  logic             mem_rd_we,
  input  logic [RADDR-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0] mem_result,
  output logic [WIDTH-1:0] fwd_d
);

  logic rs_nonzero;
  logic ex_hit;
  logic mem_hit;

  assign rs_nonzero = (rs_addr != '0);
  // A load in EX has no data yet; the top stalls on that case instead.
  assign ex_hit     = ex_rd_we && (ex_rd_addr == rs_addr) && rs_nonzero && !ex_is_load;
  assign mem_hit    = mem_rd_we && (mem_rd_addr == rs_addr) && rs_nonzero;

  always_comb begin
    fwd_d = rs_d;
    if (ex_hit) begin
      fwd_d = ex_result;
    end else if (mem_hit) begin
      fwd_d = mem_result;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Forwards and selects ALU operands into a one-entry output register; one-cycle latency.
// Stalls upstream on load-use hazards, flush, or a full register with out_ready low.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int WIDTH = REG_LEN,
  parameter int RADDR = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1_d,
  input  logic [WIDTH-1:0] rs2_d,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc,
  input  logic [RADDR-1:0] rs1_addr,
  input  logic [RADDR-1:0] rs2_addr,
  input  logic [1:0]       alu1_sel,
  input  logic [1:0]       alu2_sel,
  input  logic             ex_rd_we,
  input  logic [RADDR-1:0] ex_rd_addr,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             ex_is_load,
  input  logic             mem_rd_we,
  input  logic [RADDR-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0] mem_result,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [WIDTH-1:0] store_d,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [WIDTH-1:0] rs1_fwd;
  logic [WIDTH-1:0] rs2_fwd;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             hazard;
  logic             xfer;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic [WIDTH-1:0] store_d_q, store_d_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  fwd_unit #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs1 (
    .rs_addr     (rs1_addr),
    .rs_d        (rs1_d),
    .ex_rd_we    (ex_rd_we),
    .ex_rd_addr  (ex_rd_addr),
    .ex_result   (ex_result),
    .ex_is_load  (ex_is_load),
    .mem_rd_we   (mem_rd_we),
    .mem_rd_addr (mem_rd_addr),
    .mem_result  (mem_result),
    .fwd_d       (rs1_fwd)
  );

  fwd_unit #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs2 (
    .rs_addr     (rs2_addr),
    .rs_d        (rs2_d),
    .ex_rd_we    (ex_rd_we),
    .ex_rd_addr  (ex_rd_addr),
    .ex_result   (ex_result),
    .ex_is_load  (ex_is_load),
    .mem_rd_we   (mem_rd_we),
    .mem_rd_addr (mem_rd_addr),
    .mem_result  (mem_result),
    .fwd_d       (rs2_fwd)
  );

  always_comb begin
    op1 = '0;
    case (alu1_sel)
      ALU1_RS1: op1 = rs1_fwd;
      ALU1_PC:  op1 = pc;
      default:  op1 = '0;
    endcase
  end

  always_comb begin
    op2 = '0;
    case (alu2_sel)
      ALU2_RS2:    op2 = rs2_fwd;
      ALU2_IMM:    op2 = imm;
      ALU2_CONST4: op2 = WIDTH'(4);
      default:     op2 = '0;
    endcase
  end

  // rs2 always counts as used: store data is taken from it whatever alu2_sel says.
  assign hazard = in_valid && ex_rd_we && ex_is_load && (ex_rd_addr != '0) &&
                  (((alu1_sel == ALU1_RS1) && (ex_rd_addr == rs1_addr)) ||
                   (ex_rd_addr == rs2_addr));

  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    store_d_d   = store_d_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (xfer) begin
      alu_in1_d = op1;
      alu_in2_d = op2;
      store_d_d = rs2_fwd;
    end
    if (hazard && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      store_d_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      store_d_q   <= store_d_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign store_d   = store_d_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage: forwarding, operand selects, stalls,
// backpressure, flush and asynchronous reset, with hand-computed expectations.
module tb_alu_operand_stage;

  localparam int WIDTH = 32;
  localparam int RADDR = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs1_d, rs2_d, imm, pc;
  logic [RADDR-1:0] rs1_addr, rs2_addr;
  logic [1:0]       alu1_sel, alu2_sel;
  logic             ex_rd_we;
  logic [RADDR-1:0] ex_rd_addr;
  logic [WIDTH-1:0] ex_result;
  logic             ex_is_load;
  logic             mem_rd_we;
  logic [RADDR-1:0] mem_rd_addr;
  logic [WIDTH-1:0] mem_result;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_in1, alu_in2, store_d;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(WIDTH), .RADDR(RADDR), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .imm         (imm),
    .pc          (pc),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .alu1_sel    (alu1_sel),
    .alu2_sel    (alu2_sel),
    .ex_rd_we    (ex_rd_we),
    .ex_rd_addr  (ex_rd_addr),
    .ex_result   (ex_result),
    .ex_is_load  (ex_is_load),
    .mem_rd_we   (mem_rd_we),
    .mem_rd_addr (mem_rd_addr),
    .mem_result  (mem_result),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .store_d     (store_d),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; rs1_d = 0; rs2_d = 0; imm = 0; pc = 0;
    rs1_addr = 0; rs2_addr = 0; alu1_sel = 0; alu2_sel = 0;
    ex_rd_we = 0; ex_rd_addr = 0; ex_result = 0; ex_is_load = 0;
    mem_rd_we = 0; mem_rd_addr = 0; mem_result = 0;
    flush = 0; out_ready = 1;

    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_alu_in1", alu_in1, 32'h0);
    chk("rst_alu_in2", alu_in2, 32'h0);
    chk("rst_store_d", store_d, 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // EX bypass wins over MEM bypass
    in_valid = 1; rs1_addr = 5; rs1_d = 32'h55;
    ex_rd_we = 1; ex_rd_addr = 5; ex_result = 32'hAA;
    mem_rd_we = 1; mem_rd_addr = 5; mem_result = 32'hBB;
    alu1_sel = 2'd0; alu2_sel = 2'd1; imm = 32'h10;
    rs2_addr = 3; rs2_d = 32'h33;
    #1 chk("fwd_ex_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("fwd_ex_out_valid", 32'(out_valid), 32'h1);
    chk("fwd_ex_alu_in1", alu_in1, 32'hAA);
    chk("fwd_ex_alu_in2_imm", alu_in2, 32'h10);
    chk("fwd_ex_store_d", store_d, 32'h33);

    // MEM bypass and CONST4
    ex_rd_we = 0; rs2_addr = 5; alu2_sel = 2'd2;
    step();
    chk("fwd_mem_alu_in1", alu_in1, 32'hBB);
    chk("const4_alu_in2", alu_in2, 32'h4);
    chk("fwd_mem_store_d", store_d, 32'hBB);

    // x0 never bypassed; PC select
    alu1_sel = 2'd1; pc = 32'h100;
    rs2_addr = 0; rs2_d = 0; alu2_sel = 2'd0;
    ex_rd_we = 1; ex_rd_addr = 0; ex_result = 32'h11;
    mem_rd_addr = 0; mem_result = 32'h22;
    step();
    chk("pc_alu_in1", alu_in1, 32'h100);
    chk("x0_alu_in2", alu_in2, 32'h0);
    chk("x0_store_d", store_d, 32'h0);

    // ZERO selects, store data still bypassed
    alu1_sel = 2'd2; alu2_sel = 2'd3;
    rs2_addr = 9; rs2_d = 32'h99; ex_rd_addr = 9;
    step();
    chk("zero_alu_in1", alu_in1, 32'h0);
    chk("zero_alu_in2", alu_in2, 32'h0);
    chk("store_fwd_ex", store_d, 32'h11);

    // Load-use stall on rs1
    mem_rd_we = 0;
    ex_rd_we = 1; ex_is_load = 1; ex_rd_addr = 7;
    rs1_addr = 7; alu1_sel = 2'd0; rs2_addr = 1; alu2_sel = 2'd1; imm = 32'h20;
    #1 chk("lu_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'h1);
    chk("lu_out_valid", 32'(out_valid), 32'h0);
    ex_is_load = 0; ex_result = 32'h77;
    #1 chk("lu_release_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("lu_release_alu_in1", alu_in1, 32'h77);
    chk("lu_release_out_valid", 32'(out_valid), 32'h1);
    chk("lu_release_stall_cnt", 32'(stall_cnt), 32'h1);

    // rs1 match ignored when ALU1 uses PC
    ex_is_load = 1; alu1_sel = 2'd1; pc = 32'h200; rs2_addr = 2;
    #1 chk("lu_pc_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("lu_pc_alu_in1", alu_in1, 32'h200);

    // rs2 match stalls even with IMM on ALU2 (store data)
    rs2_addr = 7;
    #1 chk("lu_store_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("lu_store_stall_cnt", 32'(stall_cnt), 32'h2);

    // Backpressure
    ex_is_load = 0; ex_rd_we = 0; imm = 32'h30;
    step();
    chk("bp_first_out_valid", 32'(out_valid), 32'h1);
    chk("bp_first_alu_in2", alu_in2, 32'h30);
    out_ready = 0; imm = 32'h40;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'h0);
      step();
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_alu_in2_hold", alu_in2, 32'h30);
    end
    out_ready = 1;
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("bp_release_alu_in2", alu_in2, 32'h40);
    chk("bp_release_out_valid", 32'(out_valid), 32'h1);

    // Flush with a pending hazard: no transfer, no stall count
    flush = 1; ex_rd_we = 1; ex_is_load = 1; ex_rd_addr = 7; rs2_addr = 7;
    #1 chk("flush_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_stall_cnt", 32'(stall_cnt), 32'h2);
    flush = 0;
    step();
    chk("stall3_cnt", 32'(stall_cnt), 32'h3);
    ex_is_load = 0;
    step();
    chk("pre_rst_out_valid", 32'(out_valid), 32'h1);

    // Asynchronous reset away from any clock edge
    out_ready = 0; in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_alu_in1", alu_in1, 32'h0);
    chk("arst_alu_in2", alu_in2, 32'h0);
    chk("arst_store_d", store_d, 32'h0);
    chk("arst_stall_cnt", 32'(stall_cnt), 32'h0);
    out_ready = 1; ex_rd_we = 0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
